// File: rtl/matrix_frame_arb_if.sv
// Bundle of requester, swap-control and display-side signals for the
// double-buffered frame arbiter.
interface matrix_frame_arb_if;
    logic       req0_valid;
    logic [2:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [2:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       swap_req;
    logic       frame_done;
    logic [2:0] disp_addr;
    logic [7:0] disp_data;
    logic       busy;
    logic [7:0] frame_count;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output swap_req, frame_done, disp_addr,
        input  req0_ready, req1_ready, disp_data, busy, frame_count
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  swap_req, frame_done, disp_addr,
        output req0_ready, req1_ready, disp_data, busy, frame_count
    );
endinterface

// File: rtl/matrix_frame_arb.sv
// Double-buffered 8x8 LED matrix frame store: two round-robin writers fill the
// back buffer, a swap commits it at the driver's frame boundary, then a copy resyncs.
//
// state   | meaning
// IDLE    | writes granted into the back buffer
// PENDING | swap requested, waiting for frame_done from the driver
// COPY    | new front copied row by row into the back buffer
module matrix_frame_arb (
    input logic            clk,
    input logic            reset_n,
    matrix_frame_arb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] buf_a [8];
    logic [7:0] buf_b [8];
    logic       front_sel;
    logic       rr_ptr;
    logic       swap_latch;
    logic [2:0] copy_cnt;
    logic [7:0] frame_count_q;

    logic       grant0;
    logic       grant1;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] copy_row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.swap_req) state_nxt = PENDING;
            PENDING: if (bus.frame_done) state_nxt = COPY;
            COPY: begin
                if (copy_cnt == 3'd7) begin
                    state_nxt = (swap_latch || bus.swap_req) ? PENDING : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        copy_row = front_sel ? buf_b[copy_cnt] : buf_a[copy_cnt];

        // A swap request takes the cycle: no write lands in a buffer about to be committed.
        if (state == IDLE && !bus.swap_req) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end

        if (grant0) begin
            wr_en   = 1'b1;
            wr_addr = bus.req0_addr;
            wr_data = bus.req0_data;
        end else if (grant1) begin
            wr_en   = 1'b1;
            wr_addr = bus.req1_addr;
            wr_data = bus.req1_data;
        end else if (state == COPY) begin
            wr_en   = 1'b1;
            wr_addr = copy_cnt;
            wr_data = copy_row;
        end

        bus.req0_ready  = grant0 & reset_n;
        bus.req1_ready  = grant1 & reset_n;
        bus.busy        = (state != IDLE);
        bus.disp_data   = front_sel ? buf_b[bus.disp_addr] : buf_a[bus.disp_addr];
        bus.frame_count = frame_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
            front_sel     <= 1'b0;
            rr_ptr        <= 1'b0;
            swap_latch    <= 1'b0;
            copy_cnt      <= '0;
            frame_count_q <= '0;
        end else begin
            if (wr_en) begin
                if (front_sel) begin
                    buf_a[wr_addr] <= wr_data;
                end else begin
                    buf_b[wr_addr] <= wr_data;
                end
            end

            if (grant0) rr_ptr <= 1'b1;
            if (grant1) rr_ptr <= 1'b0;

            if (state == PENDING && bus.frame_done) begin
                front_sel     <= ~front_sel;
                frame_count_q <= frame_count_q + 8'd1;
                copy_cnt      <= '0;
            end

            if (state == COPY) begin
                copy_cnt <= copy_cnt + 3'd1;
                if (copy_cnt == 3'd7) begin
                    swap_latch <= 1'b0;
                end else if (bus.swap_req) begin
                    swap_latch <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_arb.sv
// Scenario bench for matrix_frame_arb: a reference model of both buffers,
// round-robin pointer and frame counter plus a queue of expected display rows.
module tb_matrix_frame_arb;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } ent_t;

    logic clk;
    logic reset_n;
    matrix_frame_arb_if bus ();

    matrix_frame_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         checks;
    int         errors;
    ent_t       sb [$];
    logic [7:0] mdl_front [8];
    logic [7:0] mdl_back  [8];
    logic       mdl_rr;
    logic [7:0] mdl_fc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mdl_front[i] = '0;
            mdl_back[i]  = '0;
        end
        mdl_rr = 1'b0;
        mdl_fc = '0;
        sb.delete();
    endtask

    task automatic model_swap();
        mdl_front = mdl_back;
        mdl_fc    = mdl_fc + 8'd1;
    endtask

    // Drives a complete swap from IDLE with no requesters active.
    task automatic do_swap(input int stall);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
        repeat (stall) @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        model_swap();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_addr  = 3'd0;
        bus.req1_addr  = 3'd1;
        bus.req0_data  = 8'h11;
        bus.req1_data  = 8'h22;
        bus.swap_req   = 1'b0;
        bus.frame_done = 1'b0;
        bus.disp_addr  = 3'd0;
        model_reset();
        #2;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.disp_data !== 8'h00) begin errors++; $display("FAIL reset_disp: got %h want 00", bus.disp_data); end
        checks++; if (bus.frame_count !== 8'h00) begin errors++; $display("FAIL reset_fc: got %0d want 0", bus.frame_count); end
        repeat (2) @(negedge clk);
        reset_n        = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_single_write();
        ent_t e;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd3;
        bus.req0_data  = 8'hA5;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b want 1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b want 0", bus.req1_ready); end
        mdl_back[3] = 8'hA5;
        mdl_rr      = 1'b1;
        sb.push_back('{addr: 3'd3, data: 8'hA5});
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.swap_req   = 1'b1;
        bus.disp_addr  = 3'd3;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_swapcyc: got %b want 0", bus.busy); end
        @(negedge clk);
        bus.swap_req = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_pending: got %b want 1", bus.busy); end
        checks++; if (bus.disp_data !== mdl_front[3]) begin errors++; $display("FAIL single_disp_before: got %h want %h", bus.disp_data, mdl_front[3]); end
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        model_swap();
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL single_sb: got empty queue want 1 entry");
        end else begin
            e = sb.pop_front();
            bus.disp_addr = e.addr;
            #1;
            if (bus.disp_data !== e.data) begin errors++; $display("FAIL single_disp_after: got %h want %h", bus.disp_data, e.data); end
        end
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL single_fc: got %0d want %0d", bus.frame_count, mdl_fc); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_copy_busy: row %0d got %b want 1", i, bus.busy); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_contention();
        logic [2:0] a0 [2];
        logic [2:0] a1 [2];
        logic [7:0] d0 [2];
        logic [7:0] d1 [2];
        int         n0;
        int         n1;
        logic       w;
        ent_t       e;
        a0 = '{3'd0, 3'd1}; d0 = '{8'h11, 8'h22};
        a1 = '{3'd4, 3'd5}; d1 = '{8'h44, 8'h55};
        n0 = 0; n1 = 0;
        for (int cyc = 0; cyc < 8 && (n0 < 2 || n1 < 2); cyc++) begin
            @(negedge clk);
            bus.req0_valid = (n0 < 2);
            bus.req1_valid = (n1 < 2);
            if (n0 < 2) begin bus.req0_addr = a0[n0]; bus.req0_data = d0[n0]; end
            if (n1 < 2) begin bus.req1_addr = a1[n1]; bus.req1_data = d1[n1]; end
            #1;
            w = (bus.req0_valid && (!bus.req1_valid || mdl_rr == 1'b0)) ? 1'b0 : 1'b1;
            checks++; if (bus.req0_ready !== (w == 1'b0)) begin errors++; $display("FAIL cont_ready0: cycle %0d got %b want %b", cyc, bus.req0_ready, (w == 1'b0)); end
            checks++; if (bus.req1_ready !== (w == 1'b1)) begin errors++; $display("FAIL cont_ready1: cycle %0d got %b want %b", cyc, bus.req1_ready, (w == 1'b1)); end
            if (w == 1'b0) begin
                mdl_back[a0[n0]] = d0[n0];
                sb.push_back('{addr: a0[n0], data: d0[n0]});
                n0++;
            end else begin
                mdl_back[a1[n1]] = d1[n1];
                sb.push_back('{addr: a1[n1], data: d1[n1]});
                n1++;
            end
            mdl_rr = ~w;
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        do_swap(3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.disp_addr = e.addr;
            #1;
            checks++; if (bus.disp_data !== e.data) begin errors++; $display("FAIL cont_sb: addr %0d got %h want %h", e.addr, bus.disp_data, e.data); end
        end
        for (int r = 0; r < 8; r++) begin
            bus.disp_addr = r[2:0];
            #1;
            checks++; if (bus.disp_data !== mdl_front[r]) begin errors++; $display("FAIL cont_row: row %0d got %h want %h", r, bus.disp_data, mdl_front[r]); end
        end
    endtask

    task automatic test_stall();
        ent_t e;
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd6;
        bus.req1_data  = 8'h3C;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL stall_single_ready1: got %b want 1", bus.req1_ready); end
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL stall_single_ready0: got %b want 0", bus.req0_ready); end
        mdl_back[6] = 8'h3C;
        mdl_rr      = 1'b0;
        sb.push_back('{addr: 3'd6, data: 8'h3C});
        @(negedge clk);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd7;
        bus.req0_data  = 8'h77;
        bus.swap_req   = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL stall_swapcyc_ready: got %b want 0", bus.req0_ready); end
        @(negedge clk);
        bus.swap_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++; if (bus.busy !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL stall_pending: cycle %0d got busy=%b ready=%b want busy=1 ready=0", i, bus.busy, bus.req0_ready); end
            if (i == 19) bus.frame_done = 1'b1;
            @(negedge clk);
        end
        bus.frame_done = 1'b0;
        model_swap();
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (bus.busy !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL stall_copy: row %0d got busy=%b ready=%b want busy=1 ready=0", i, bus.busy, bus.req0_ready); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL stall_resume: got ready=%b busy=%b want ready=1 busy=0", bus.req0_ready, bus.busy); end
        mdl_back[7] = 8'h77;
        mdl_rr      = 1'b1;
        sb.push_back('{addr: 3'd7, data: 8'h77});
        @(negedge clk);
        bus.req0_valid = 1'b0;
        do_swap(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.disp_addr = e.addr;
            #1;
            checks++; if (bus.disp_data !== e.data) begin errors++; $display("FAIL stall_sb: addr %0d got %h want %h", e.addr, bus.disp_data, e.data); end
        end
        for (int r = 0; r < 8; r++) begin
            bus.disp_addr = r[2:0];
            #1;
            checks++; if (bus.disp_data !== mdl_front[r]) begin errors++; $display("FAIL stall_row: row %0d got %h want %h", r, bus.disp_data, mdl_front[r]); end
        end
    endtask

    task automatic test_latched_swap();
        @(negedge clk);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
        @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        model_swap();
        repeat (2) @(negedge clk);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL latch_pending: got busy=%b want 1", bus.busy); end
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL latch_fc_hold: got %0d want %0d", bus.frame_count, mdl_fc); end
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL latch_pending_hold: got busy=%b want 1", bus.busy); end
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req   = 1'b0;
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        model_swap();
        #1;
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL latch_fc_inc: got %0d want %0d", bus.frame_count, mdl_fc); end
        repeat (8) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL latch_pending_swap_ignored: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_same_cycle();
        ent_t e;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd2;
        bus.req0_data  = 8'h5A;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL same_ready0: got %b want 1", bus.req0_ready); end
        mdl_back[2] = 8'h5A;
        mdl_rr      = 1'b1;
        sb.push_back('{addr: 3'd2, data: 8'h5A});
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.swap_req   = 1'b1;
        bus.frame_done = 1'b1;
        bus.disp_addr  = 3'd2;
        @(negedge clk);
        bus.swap_req   = 1'b0;
        bus.frame_done = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", bus.busy); end
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL same_fc_hold: got %0d want %0d", bus.frame_count, mdl_fc); end
        checks++; if (bus.disp_data !== mdl_front[2]) begin errors++; $display("FAIL same_disp_hold: got %h want %h", bus.disp_data, mdl_front[2]); end
        repeat (2) @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        model_swap();
        #1;
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL same_fc_inc: got %0d want %0d", bus.frame_count, mdl_fc); end
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL same_sb: got empty queue want 1 entry");
        end else begin
            e = sb.pop_front();
            bus.disp_addr = e.addr;
            #1;
            if (bus.disp_data !== e.data) begin errors++; $display("FAIL same_disp_new: got %h want %h", bus.disp_data, e.data); end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_copy();
        for (int k = 0; k < 256 && mdl_fc != 8'd255; k++) begin
            do_swap(0);
        end
        #1;
        checks++; if (bus.frame_count !== 8'd255) begin errors++; $display("FAIL rst_fc_255: got %0d want 255", bus.frame_count); end
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd1;
        bus.req1_data  = 8'hEE;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b want 1", bus.req1_ready); end
        mdl_back[1] = 8'hEE;
        mdl_rr      = 1'b0;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        bus.swap_req   = 1'b1;
        @(negedge clk);
        bus.swap_req   = 1'b0;
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        model_swap();
        bus.disp_addr = 3'd1;
        #1;
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL rst_fc_wrap: got %0d want %0d", bus.frame_count, mdl_fc); end
        checks++; if (bus.disp_data !== mdl_front[1]) begin errors++; $display("FAIL rst_disp_pre: got %h want %h", bus.disp_data, mdl_front[1]); end
        repeat (4) @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        reset_n        = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready); end
        checks++; if (bus.disp_data !== mdl_front[1]) begin errors++; $display("FAIL rst_disp: got %h want %h", bus.disp_data, mdl_front[1]); end
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL rst_fc: got %0d want %0d", bus.frame_count, mdl_fc); end
        @(negedge clk);
        reset_n        = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        do_swap(0);
        for (int r = 0; r < 8; r++) begin
            bus.disp_addr = r[2:0];
            #1;
            checks++; if (bus.disp_data !== mdl_front[r]) begin errors++; $display("FAIL rst_row_after: row %0d got %h want %h", r, bus.disp_data, mdl_front[r]); end
        end
        checks++; if (bus.frame_count !== mdl_fc) begin errors++; $display("FAIL rst_fc_after: got %0d want %0d", bus.frame_count, mdl_fc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_write();
        test_contention();
        test_stall();
        test_latched_swap();
        test_same_cycle();
        test_reset_mid_copy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
